prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the LEGv8 pipeline's fetch stage. Accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, writes them sequentially into instruction memory from word address 0, then raises `cpu_run` to release the CPU. Detects malformed length headers and stalled streams, parking in an error state until restarted.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/word_packer.sv | 42 ++++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The state encoding and error codes are visible at the loader ports and to its testbench.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN0    = 2'd1;
  localparam logic [1:0] ERR_LENBIG  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned LEN_BYTES = 2;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Raises a one-cycle word_valid pulse after the 4th byte; clear drops any partial word.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] part_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      part_q     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        case (byte_idx)
          2'd0: part_q[7:0]   <= byte_data;
          2'd1: part_q[15:8]  <= byte_data;
          2'd2: part_q[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, part_q};
            word_valid <= 1'b1;
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: reads a 16-bit little-endian word count, then streams that many
// 32-bit words into instruction memory from address 0 and releases the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              cpu_run,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [32:0] CAP   = 33'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        len_lo_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TMO_W-1:0]  tmo_q;

  logic        accept;
  logic        start_ok;
  logic        tmo_hit;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] n_hdr;
  logic [15:0] n_m1;

  assign busy     = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign in_ready = busy;
  assign cpu_run  = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign err_code = err_code_q;
  assign im_we    = word_valid;
  assign im_addr  = addr_q;
  assign im_wdata = word;

  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign n_hdr    = {in_data, len_lo_q};
  assign n_m1     = n_hdr - 16'd1;
  assign tmo_hit  = busy && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));

  word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q != ST_DATA),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_LO;
          err_code_d = ERR_NONE;
        end
      end
      ST_LEN_LO: begin
        if (accept) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          if (n_hdr == 16'd0) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LEN0;
          end else if ({17'd0, n_hdr} > CAP) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LENBIG;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid && (addr_q == last_idx_q)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A completed final write wins over a coincident timeout.
    if (tmo_hit && (state_d == state_q)) begin
      state_d    = ST_ERR;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
      len_lo_q   <= '0;
      last_idx_q <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;

      if (state_q == ST_LEN_LO && accept) len_lo_q <= in_data;
      if (state_q == ST_LEN_HI && accept) last_idx_q <= ADDR_W'(n_m1);

      // The index holds on the last word so a full-capacity load ends at the top address.
      if (start_ok) addr_q <= '0;
      else if (word_valid && (addr_q != last_idx_q)) addr_q <= addr_q + 1'b1;

      if (!busy || accept || start_ok) tmo_q <= '0;
      else tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: header table, full loads, timeout, reset and restart.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              cpu_run;
  logic              err;
  logic [1:0]        err_code;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .cpu_run  (cpu_run),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned we_count = 0;
  logic [39:0] sb_q[$];

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_err;
    logic [1:0] exp_code;
  } hdr_vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      we_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr %0h data %0h expected no write", im_addr, im_wdata);
      end else begin
        chk("im_write", {im_addr, im_wdata}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL send_byte: got in_ready 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    sb_q.push_back({a, w});
    for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  hdr_vec_t vecs[6];
  int unsigned we_before;
  logic [31:0] rw;

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b1, ERR_LEN0};
    vecs[1] = '{8'h01, 8'h01, 1'b1, ERR_LENBIG};
    vecs[2] = '{8'h00, 8'h02, 1'b1, ERR_LENBIG};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, ERR_LENBIG};
    vecs[4] = '{8'h00, 8'h01, 1'b0, ERR_NONE};
    vecs[5] = '{8'h01, 8'h00, 1'b0, ERR_NONE};

    tick();
    tick();
    chk("reset_flags", 40'({in_ready, im_we, busy, cpu_run, err, err_code}), 40'd0);
    chk("reset_addr_data", {im_addr, im_wdata}, 40'd0);
    rst_n = 1'b1;

    // Basic two-word load, back-to-back bytes.
    do_start();
    chk("start_busy", 40'({busy, in_ready, cpu_run}), 40'b110);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(8'd0, 32'h12345678);
    send_word(8'd1, 32'hDEADBEEF);
    chk("run_k1", 40'(cpu_run), 40'd0);
    tick();
    chk("run_k2", 40'({cpu_run, busy, in_ready, err}), 40'b1000);
    chk("sb_basic", 40'(sb_q.size()), 40'd0);

    // Header table.
    for (int unsigned i = 0; i < 6; i++) begin
      do_reset();
      do_start();
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      chk("hdr_err", 40'({err, err_code}), 40'({vecs[i].exp_err, vecs[i].exp_code}));
      chk("hdr_ready", 40'({in_ready, busy}), 40'({!vecs[i].exp_err, !vecs[i].exp_err}));
    end

    // Restart out of ERR.
    do_reset();
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    chk("len0_err", 40'({err, err_code, in_ready}), 40'({1'b1, ERR_LEN0, 1'b0}));
    do_start();
    chk("err_restart", 40'({err, err_code, busy}), 40'({1'b0, ERR_NONE, 1'b1}));

    // Full capacity: 256 words.
    do_reset();
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int unsigned i = 0; i < 256; i++) begin
      rw = {i[7:0] ^ 8'hA5, i[7:0], ~i[7:0], i[7:0]};
      send_word(i[7:0], rw);
    end
    tick();
    chk("full_done", 40'({cpu_run, err}), 40'b10);
    chk("sb_full", 40'(sb_q.size()), 40'd0);

    // Timeout with a partial word pending.
    do_reset();
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TIMEOUT - 1) tick();
    chk("tmo_before", 40'({err, busy}), 40'b01);
    tick();
    chk("tmo_err", 40'({err, err_code, in_ready}), 40'({1'b1, ERR_TIMEOUT, 1'b0}));

    // Random gaps, with a start pulse mid-stream that must be ignored.
    do_reset();
    do_start();
    send_byte(8'h04);
    send_byte(8'h00);
    we_before = we_count;
    for (int unsigned w = 0; w < 4; w++) begin
      rw = $urandom;
      sb_q.push_back({w[7:0], rw});
      if (w == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", 40'({busy, err}), 40'b10);
      end
      for (int unsigned b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 10)) tick();
        send_byte(rw[8*b +: 8]);
      end
    end
    tick();
    chk("gap_done", 40'(cpu_run), 40'd1);
    chk("gap_we_count", 40'(we_count - we_before), 40'd4);

    // Reset mid-load, then restart from DONE.
    do_reset();
    do_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(8'd0, 32'hCAFEF00D);
    send_byte(8'h99);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_flags", 40'({in_ready, im_we, busy, cpu_run, err, err_code}), 40'd0);
    chk("midrst_addr", 40'(im_addr), 40'd0);
    repeat (3) tick();
    do_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(8'd0, 32'h01234567);
    tick();
    chk("reload1_done", 40'(cpu_run), 40'd1);
    do_start();
    chk("done_restart", 40'({cpu_run, busy}), 40'b01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(8'd0, 32'h89ABCDEF);
    tick();
    chk("reload2_done", 40'(cpu_run), 40'd1);

    tick();
    tick();
    chk("sb_empty", 40'(sb_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
